// File: rtl/xsleenacore_prio_mixer_if.sv
// CPU palette-access bus shared by the priority mixer and its host.
// The host (master) drives the request, the mixer (slave) returns data and ready.
interface xsleenacore_prio_mixer_if #(
  parameter int AB_W = 10
);
  logic            CPU_CSn;
  logic            CPU_RW;
  logic [AB_W-1:0] CPU_AB;
  logic [7:0]      CPU_DIN;
  logic [7:0]      CPU_DOUT;
  logic            CPU_RDY;

  modport master (
    output CPU_CSn, CPU_RW, CPU_AB, CPU_DIN,
    input  CPU_DOUT, CPU_RDY
  );

  modport slave (
    input  CPU_CSn, CPU_RW, CPU_AB, CPU_DIN,
    output CPU_DOUT, CPU_RDY
  );
endinterface

// File: rtl/xsleenacore_prio_mixer.sv
// Priority-table layer mixer with a CPU-shared palette.
// Inputs are captured on the sampling PIX_CE edge. The table lookup, the
// palette read and the output register then follow as three further ranks,
// so a pixel appears on VIDEO_* three PIX_CE edges after it was sampled.
// The palette RAMs are single-ported. A CPU access only starts on a cycle
// without PIX_CE. A PIX_CE that lands in the access cycle has its palette
// read replayed on the following cycle. This assumes PIX_CE is never high
// on two consecutive cycles.
module xsleenacore_prio_mixer #(
  parameter int NUM_LAYERS = 4,
  parameter int LCOL_W     = 7,
  parameter int PRI_W      = 3
) (
  input  logic                         clk,
  input  logic                         RSTn,
  input  logic                         PIX_CE,
  input  logic                         BLKn,
  input  logic [NUM_LAYERS*LCOL_W-1:0] LAYER_COL,
  input  logic [NUM_LAYERS-1:0]        LAYER_EN,
  input  logic [PRI_W-1:0]             PRI,
  xsleenacore_prio_mixer_if.slave      cpu,
  input  logic                         bram_cs,
  input  logic                         bram_wr,
  input  logic [19:0]                  bram_addr,
  input  logic [7:0]                   bram_data,
  output logic [3:0]                   VIDEO_R,
  output logic [3:0]                   VIDEO_G,
  output logic [3:0]                   VIDEO_B,
  output logic                         VIDEO_DE
);
  localparam int LI_W   = $clog2(NUM_LAYERS);
  localparam int PAL_AW = LI_W + LCOL_W;
  localparam int PT_AW  = PRI_W + NUM_LAYERS;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACCESS, ST_DONE} cpu_state_e;

  cpu_state_e state, state_nxt;

  // Transparency vector, pipeline ranks and palette storage.
  logic [NUM_LAYERS-1:0]        t;
  logic [PT_AW-1:0]             r1_tidx;
  logic [NUM_LAYERS*LCOL_W-1:0] r1_col;
  logic                         r1_blk;
  logic [LI_W-1:0]              tab_out, win;
  logic [LCOL_W-1:0]            win_col;
  logic [PAL_AW-1:0]            r2_addr, hold_addr, vid_addr;
  logic                         r2_blk, r3_blk;
  logic [7:0]                   vid_gr, vid_b;
  logic                         pend, acc, vid_rd;
  logic [LI_W-1:0]              prio_tab [2**PT_AW];
  logic [7:0]                   pal_gr   [2**PAL_AW];
  logic [7:0]                   pal_b    [2**PAL_AW];

  // CPU request captured when the FSM leaves IDLE.
  logic [PAL_AW:0] ab_q;
  logic            rw_q;
  logic [7:0]      din_q;
  logic [7:0]      cpu_rd;

  // A layer is transparent when its pen is 0 or when it is disabled.
  always_comb begin
    // NOTE: give every always_comb output a default first so that no path leaves it unassigned and infers a latch.
    t = '0;
    for (int k = 0; k < NUM_LAYERS; k++)
      t[k] = (LAYER_COL[k*LCOL_W +: 4] == 4'h0) || !LAYER_EN[k];
  end

  // Table load port. The table has no reset, so its contents survive RSTn.
  always_ff @(posedge clk) begin
    // NOTE: RAM arrays are left out of reset; resetting them would prevent RAM inference and would also wipe loaded contents.
    if (bram_cs && bram_wr)
      prio_tab[bram_addr[PT_AW-1:0]] <= bram_data[LI_W-1:0];
  end

  // Winner lookup from the registered table index. Out-of-range results fall back to layer 0.
  always_comb begin
    tab_out = prio_tab[r1_tidx];
    win     = (int'(tab_out) >= NUM_LAYERS) ? '0 : tab_out;
    win_col = r1_col[int'(win)*LCOL_W +: LCOL_W];
  end

  // Video pipeline: input capture, winner/colour select, output register.
  always_ff @(posedge clk or negedge RSTn) begin
    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    if (!RSTn) begin
      r1_tidx  <= '0;
      r1_col   <= '0;
      r1_blk   <= 1'b0;
      r2_addr  <= '0;
      r2_blk   <= 1'b0;
      r3_blk   <= 1'b0;
      VIDEO_R  <= 4'h0;
      VIDEO_G  <= 4'h0;
      VIDEO_B  <= 4'h0;
      VIDEO_DE <= 1'b0;
    end else if (PIX_CE) begin
      r1_tidx  <= {PRI, t};
      r1_col   <= LAYER_COL;
      r1_blk   <= BLKn;
      r2_addr  <= {win, win_col};
      r2_blk   <= r1_blk;
      r3_blk   <= r2_blk;
      VIDEO_R  <= r3_blk ? vid_gr[3:0] : 4'h0;
      VIDEO_G  <= r3_blk ? vid_gr[7:4] : 4'h0;
      VIDEO_B  <= r3_blk ? vid_b[3:0]  : 4'h0;
      VIDEO_DE <= r3_blk;
    end
  end

  // Remember a palette read that lost the port to the CPU, for replay next cycle.
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      pend      <= 1'b0;
      hold_addr <= '0;
    end else begin
      pend <= PIX_CE && acc;
      if (PIX_CE && acc)
        hold_addr <= r2_addr;
    end
  end

  assign vid_rd   = (PIX_CE && !acc) || pend;
  assign vid_addr = pend ? hold_addr : r2_addr;

  // Single-port palette. The CPU owns the port in ACCESS; otherwise video reads it.
  always_ff @(posedge clk) begin
    if (acc) begin
      if (!rw_q) begin
        if (ab_q[PAL_AW]) pal_b[ab_q[PAL_AW-1:0]]  <= {4'h0, din_q[3:0]};
        else              pal_gr[ab_q[PAL_AW-1:0]] <= din_q;
        cpu_rd <= 8'hFF;
      end else begin
        cpu_rd <= ab_q[PAL_AW] ? pal_b[ab_q[PAL_AW-1:0]] : pal_gr[ab_q[PAL_AW-1:0]];
      end
    end else if (vid_rd) begin
      vid_gr <= pal_gr[vid_addr];
      vid_b  <= pal_b[vid_addr];
    end
  end

  // Latch the CPU request as the FSM leaves IDLE. Later bus changes are ignored.
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      ab_q  <= '0;
      rw_q  <= 1'b1;
      din_q <= 8'h00;
    end else if (state == ST_IDLE && !cpu.CPU_CSn) begin
      ab_q  <= cpu.CPU_AB;
      rw_q  <= cpu.CPU_RW;
      din_q <= cpu.CPU_DIN;
    end
  end

  // CPU arbiter state register.
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // CPU arbiter next state: wait for a pixel-free cycle, access once, then hold until release.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (!cpu.CPU_CSn) state_nxt = PIX_CE ? ST_WAIT : ST_ACCESS;
      ST_WAIT:   if (cpu.CPU_CSn)  state_nxt = ST_IDLE;
                 else if (!PIX_CE) state_nxt = ST_ACCESS;
      ST_ACCESS: state_nxt = ST_DONE;
      ST_DONE:   if (cpu.CPU_CSn)  state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // CPU arbiter outputs.
  always_comb begin
    acc          = (state == ST_ACCESS);
    cpu.CPU_RDY  = (state == ST_DONE);
    cpu.CPU_DOUT = (state == ST_DONE) ? cpu_rd : 8'hFF;
  end
endmodule
